// File: rtl/reg_delay_line.sv
// reg_delay_line
//   Tapped shift register of DEPTH signed N-bit words. Each word has a valid
//   bit that travels with it. A saturating fill counter tracks the number of
//   enabled shifts since the last reset or flush. The output tap is selected
//   at run time.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (highest priority)
//   en         1 = shift every stage by one, 0 = hold everything
//   flush      synchronous clear of stages, valid bits and fill count
//   in_valid   qualifier captured alongside in
//   in         signed word entering stage 0
//   sel        requested delay in enabled cycles (0 -> 1, >DEPTH -> DEPTH)
//   out        word at the selected tap (purely from registers)
//   out_valid  valid bit at the selected tap
//   full       fill count has reached DEPTH
//   count      enabled shifts since last clear, saturating at DEPTH
module reg_delay_line #(
  parameter int N     = 8,
  parameter int DEPTH = 12,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic signed [N-1:0]    in,
  input  logic        [SELW-1:0] sel,
  output logic signed [N-1:0]    out,
  output logic                   out_valid,
  output logic                   full,
  output logic        [SELW-1:0] count
);

  localparam int TAPW = $clog2(DEPTH);

  logic signed [N-1:0]    r_stage [DEPTH];
  logic        [DEPTH-1:0] r_valid;
  logic        [SELW-1:0]  r_count;
  logic        [TAPW-1:0]  w_tap;
  logic                    w_clear;

  assign w_clear = rst | flush;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_stage[k] <= '0;
      end
      r_valid <= '0;
      r_count <= '0;
    end else if (en) begin
      r_stage[0] <= in;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
      r_valid <= {r_valid[DEPTH-2:0], in_valid};
      if (r_count != SELW'(DEPTH)) begin
        r_count <= r_count + SELW'(1);
      end
    end
  end

  // Delay d maps to stage index d-1; sel=0 is treated as d=1 and anything
  // beyond DEPTH is clamped to the last stage.
  always_comb begin
    w_tap = '0;
    if (sel == '0) begin
      w_tap = '0;
    end else if (sel > SELW'(DEPTH)) begin
      w_tap = TAPW'(DEPTH - 1);
    end else begin
      w_tap = TAPW'(sel - SELW'(1));
    end
  end

  assign out       = r_stage[w_tap];
  assign out_valid = r_valid[w_tap];
  assign count     = r_count;
  assign full      = (r_count == SELW'(DEPTH));

endmodule

// File: doc/reg_delay_line.md
REG_DELAY_LINE -- requirements
Module: reg_delay_line

Interface
Parameters:
REQ-001 SHALL: N, default 8, data word width in bits (signed).
REQ-002 SHALL: DEPTH, default 12, number of register stages (legal range 2..64).
REQ-003 SHALL: SELW, default $clog2(DEPTH+1), width of the delay-select port.
Ports:
REQ-004 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL: en  input  1  shift enable; 1 = advance all stages, 0 = hold all stages.
REQ-007 SHALL: flush  input  1  synchronous clear of all data, valid bits and fill count.
REQ-008 SHALL: in_valid  input  1  qualifier for in, captured alongside it.
REQ-009 SHALL: in  input  N  signed data word entering stage 0.
REQ-010 SHALL: sel  input  SELW  requested delay in enabled cycles.
REQ-011 SHALL: out  output  N  signed word at the selected tap.
REQ-012 SHALL: out_valid  output  1  valid bit at the selected tap.
REQ-013 SHALL: full  output  1  high when fill count equals DEPTH.
REQ-014 SHALL: count  output  SELW  fill count, enabled shifts since last clear, saturating at DEPTH.

Function
REQ-015 SHALL: state = data stages stage[0..DEPTH-1] (N bits each), valid bits v[0..DEPTH-1], counter count.
REQ-016 SHALL: priority per edge: rst > flush > en > hold.
REQ-017 SHALL: en=1 (no rst/flush): stage[0]<=in, v[0]<=in_valid, stage[k]<=stage[k-1], v[k]<=v[k-1] for k=1..DEPTH-1; stage[DEPTH-1] contents discarded.
REQ-018 SHALL: en=0: every stage, valid bit and count holds its value; in and in_valid ignored.
REQ-019 SHALL: effective delay d = 1 if sel=0, DEPTH if sel>DEPTH, else sel.
REQ-020 SHALL: out = stage[d-1], out_valid = v[d-1], combinational mux from registers only (no path from in to out).
REQ-021 SHALL: word presented with en=1 at edge t appears on out after exactly d further enabled edges counting edge t (d=1: visible right after edge t).
REQ-022 SHALL: sel may change any cycle; out/out_valid follow new tap in same cycle, stage contents unaffected.
REQ-023 SHALL: count increments by 1 on each en=1 edge while count<DEPTH, holds at DEPTH thereafter, independent of in_valid.
REQ-024 SHALL: full = (count==DEPTH), combinational from count.
REQ-025 SHALL: flush=1 zeroes all stages, clears all v, sets count=0, regardless of en; in on that edge is not captured.
REQ-026 SHALL: flush and en asserted together: flush wins; next edge with en=1 loads stage[0] normally.
REQ-027 SHALL: data passes unmodified; no sign extension, rounding or saturation of words.

Reset
REQ-028 SHALL: on rst=1 edge: all stages 0, all v 0, count 0; hence out=0, out_valid=0, full=0 from next cycle.
REQ-029 SHALL: rst mid-operation discards all in-flight words; no word captured on a reset edge.
REQ-030 SHALL: after rst deasserts, first en=1 edge behaves as REQ-017 with count 0->1.

Verification
REQ-031 SHALL: default params, sel=12, en=1, in_valid=1, in=1,2,3,... -> out=0/out_valid=0 until after 12th edge, then out=1, then 2,3,... one per cycle; full rises with 12th edge.
REQ-032 SHALL: sel=3, push -5 (0xFB) then en=0 for 4 cycles, then en=1 -> out=-5 only after 3rd enabled edge, unchanged during hold; count advances only on enabled edges.
REQ-033 SHALL: sel=0 and sel=15 with in=0x7F -> behave as d=1 and d=12 respectively.
REQ-034 SHALL: fill 6 words, assert flush with en=1 and in=0x55 -> next cycle all taps 0, out_valid=0, count=0; 0x55 never appears.
REQ-035 SHALL: alternating in_valid 1,0,1,0 with sel=2 -> out_valid follows 1,0,1,0 delayed 2 edges; rst asserted mid-stream -> out=0, out_valid=0, count=0 next cycle.
